// File: rtl/ifetch_if.sv
// Fetch-stage bundle: instruction memory request/ack, redirect and syscall inputs,
// and the registered I1/PC1 stage-2 outputs toward decode.
interface ifetch_if;
    logic [31:0] IMemAddr;
    logic        IMemReq;
    logic [31:0] IMemData;
    logic        IMemAck;
    logic        Stall;
    logic        instIsSyscall;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic [31:0] I1;
    logic [31:0] PC1;
    logic        I1Valid;

    modport master (
        output IMemAddr, IMemReq, I1, PC1, I1Valid,
        input  IMemData, IMemAck, Stall, instIsSyscall, BranchTaken, BranchTarget
    );

    modport slave (
        input  IMemAddr, IMemReq, I1, PC1, I1Valid,
        output IMemData, IMemAck, Stall, instIsSyscall, BranchTaken, BranchTarget
    );
endinterface

// File: rtl/ifetch.sv
// Instruction fetch stage: PC, one-cycle fetch into I1, delayed-branch redirect.
// Define IFETCH_SYSCALL_STALL_EN to insert two fetch bubbles after a syscall leaves I1.
module ifetch #(
    parameter logic [31:0] RESET_VECTOR = 32'h0040_0000
) (
    input logic      clk,
    input logic      reset,
    ifetch_if.master bus
);
    // state | meaning
    // RUN   | normal fetch, one request per unstalled cycle
    // SYS1  | first bubble after a syscall left I1
    // SYS2  | second bubble, fetch resumes at the held PC next
    typedef enum logic [1:0] {
        RUN  = 2'd0,
        SYS1 = 2'd1,
        SYS2 = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic        pend, pend_nxt;
    logic [31:0] pend_tgt, pend_tgt_nxt;
    logic [31:0] i1, i1_nxt;
    logic [31:0] pc1, pc1_nxt;
    logic        i1_valid, i1_valid_nxt;

    logic        run_go;
    logic        sys_take;
    logic        fetch_done;
    logic [31:0] branch_tgt;

    assign run_go     = (state == RUN) && !bus.Stall;
    assign branch_tgt = {bus.BranchTarget[31:2], 2'b00};

`ifdef IFETCH_SYSCALL_STALL_EN
    assign sys_take = run_go && i1_valid && bus.instIsSyscall;
`else
    logic unused_syscall;
    assign unused_syscall = bus.instIsSyscall;
    assign sys_take       = 1'b0;
`endif

    // A syscall leaving I1 steals the edge, so any ack that cycle is dropped.
    assign fetch_done = run_go && bus.IMemAck && !sys_take;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN: begin
                if (sys_take) begin
                    state_nxt = SYS1;
                end
            end
            SYS1: begin
                if (!bus.Stall) begin
                    state_nxt = SYS2;
                end
            end
            SYS2: begin
                if (!bus.Stall) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        pc_nxt       = pc;
        pend_nxt     = pend;
        pend_tgt_nxt = pend_tgt;
        i1_nxt       = i1;
        pc1_nxt      = pc1;
        i1_valid_nxt = i1_valid;

        if (fetch_done) begin
            i1_nxt       = bus.IMemData;
            pc1_nxt      = pc;
            i1_valid_nxt = 1'b1;
            pend_nxt     = 1'b0;
            // This fetch is the delay slot of whichever redirect is newest.
            if (bus.BranchTaken) begin
                pc_nxt = branch_tgt;
            end else if (pend) begin
                pc_nxt = pend_tgt;
            end else begin
                pc_nxt = pc + 32'd4;
            end
        end else begin
            if (!bus.Stall) begin
                i1_nxt       = 32'h0;
                i1_valid_nxt = 1'b0;
            end
            if (bus.BranchTaken) begin
                pend_nxt     = 1'b1;
                pend_tgt_nxt = branch_tgt;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc       <= RESET_VECTOR;
            pend     <= 1'b0;
            pend_tgt <= 32'h0;
            i1       <= 32'h0;
            pc1      <= 32'h0;
            i1_valid <= 1'b0;
        end else begin
            pc       <= pc_nxt;
            pend     <= pend_nxt;
            pend_tgt <= pend_tgt_nxt;
            i1       <= i1_nxt;
            pc1      <= pc1_nxt;
            i1_valid <= i1_valid_nxt;
        end
    end

    assign bus.IMemAddr = pc;
    assign bus.IMemReq  = run_go;
    assign bus.I1       = i1;
    assign bus.PC1      = pc1;
    assign bus.I1Valid  = i1_valid;

endmodule
